// File: rtl/data_partition_pkg.sv
// Shared constants for data_partition_merge: FSM state encoding, sub-index width and
// descriptor field offsets ({sub_idx, id, addr, len} in, {id, base_addr, total_len} out).
package data_partition_pkg;

    localparam int unsigned SubIdxW = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StAcc  = 2'd1;
    localparam state_t StEmit = 2'd2;
    localparam state_t StDrop = 2'd3;

    localparam int unsigned FragLenLsb = 0;
    localparam int unsigned OutLenLsb  = 0;

    function automatic int unsigned frag_addr_lsb(input int unsigned lsize);
        return lsize;
    endfunction

    function automatic int unsigned frag_id_lsb(input int unsigned lsize, input int unsigned asize);
        return lsize + asize;
    endfunction

    function automatic int unsigned frag_sub_lsb(input int unsigned lsize, input int unsigned asize,
                                                 input int unsigned idsize);
        return lsize + asize + idsize;
    endfunction

    function automatic int unsigned out_addr_lsb(input int unsigned lsize);
        return lsize;
    endfunction

    function automatic int unsigned out_id_lsb(input int unsigned lsize, input int unsigned asize);
        return lsize + asize;
    endfunction

endpackage

// File: rtl/data_partition_merge.sv
// Merges indexed fragments of one transaction into a single {id, base_addr, total_len} descriptor.
// Fragment checking, err and err_cnt are active only with DATA_PARTITION_MERGE_CHECK_EN defined.
module data_partition_merge
    import data_partition_pkg::*;
#(
    parameter int unsigned PLEN      = 128,
    parameter int unsigned LSIZE     = 12,
    parameter int unsigned IDSIZE    = 4,
    parameter int unsigned ASIZE     = 16,
    parameter int unsigned ADDR_STEP = 1
) (
    input  logic                                  clock,
    input  logic                                  rst_n,
    input  logic                                  frag_valid,
    output logic                                  frag_ready,
    input  logic [SubIdxW+IDSIZE+ASIZE+LSIZE-1:0] frag_data,
    input  logic                                  frag_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [IDSIZE+ASIZE+LSIZE-1:0]         out_data,
    output logic                                  err,
    output logic [15:0]                           err_cnt
);

    localparam int unsigned AccW       = LSIZE + SubIdxW;
    localparam int unsigned SubLsb     = frag_sub_lsb(LSIZE, ASIZE, IDSIZE);
    localparam int unsigned IdLsb      = frag_id_lsb(LSIZE, ASIZE);
    localparam int unsigned AddrLsb    = frag_addr_lsb(LSIZE);
    localparam int unsigned OutIdLsb   = out_id_lsb(LSIZE, ASIZE);
    localparam int unsigned OutAddrLsb = out_addr_lsb(LSIZE);

    localparam logic [LSIZE-1:0] FullLen   = LSIZE'(PLEN - 1);
    localparam logic [AccW:0]    PlenBeats = (AccW + 1)'(PLEN);
    localparam logic [ASIZE-1:0] AddrInc   = ASIZE'(ADDR_STEP * PLEN / 1024);

    logic [SubIdxW-1:0] f_sub;
    logic [IDSIZE-1:0]  f_id;
    logic [ASIZE-1:0]   f_addr;
    logic [LSIZE-1:0]   f_len;

    assign f_sub  = frag_data[SubLsb +: SubIdxW];
    assign f_id   = frag_data[IdLsb +: IDSIZE];
    assign f_addr = frag_data[AddrLsb +: ASIZE];
    assign f_len  = frag_data[FragLenLsb +: LSIZE];

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic [IDSIZE-1:0]  id_q, id_d;
    logic [ASIZE-1:0]   addr_q, addr_d;
    logic [LSIZE-1:0]   acc_q, acc_d;
    logic [AccW:0]      base_q, base_d;
    logic [SubIdxW-1:0] exp_idx_q, exp_idx_d;
    logic [ASIZE-1:0]   exp_addr_q, exp_addr_d;

    logic               accept;
    logic               viol;
    logic [AccW:0]      base_sel;
    logic [AccW+1:0]    acc_sum;

    assign accept = frag_valid && ready_q;

    // base_q counts the beats of all fragments before the current one, so the index wrap at
    // 16 fragments does not lose length.
    assign base_sel = (state_q == StAcc) ? base_q : '0;
    assign acc_sum  = (AccW + 2)'(base_sel) + (AccW + 2)'(f_len);

`ifdef DATA_PARTITION_MERGE_CHECK_EN
    logic        err_q;
    logic [15:0] err_cnt_q;
    logic        len_bad;
    logic        acc_ovf;

    assign len_bad = !frag_last && (f_len != FullLen);
    assign acc_ovf = |acc_sum[AccW+1:LSIZE];

    always_comb begin
        viol = 1'b0;
        case (state_q)
            StIdle:  viol = (f_sub != '0) || len_bad;
            StAcc:   viol = (f_sub != exp_idx_q) || (f_id != id_q) || (f_addr != exp_addr_q) ||
                            len_bad || acc_ovf;
            default: viol = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= accept && viol;
            if (accept && viol && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err     = err_q;
    assign err_cnt = err_cnt_q;
`else
    logic unused_chk;
    assign unused_chk = ^{f_sub, acc_sum[AccW+1:LSIZE]};
    assign viol       = 1'b0;
    assign err        = 1'b0;
    assign err_cnt    = '0;
`endif

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        addr_d     = addr_q;
        acc_d      = acc_q;
        base_d     = base_q;
        exp_idx_d  = exp_idx_q;
        exp_addr_d = exp_addr_q;
        case (state_q)
            StIdle, StAcc: begin
                if (accept) begin
                    if (viol) begin
                        state_d = frag_last ? StIdle : StDrop;
                    end else begin
                        if (state_q == StIdle) begin
                            id_d       = f_id;
                            addr_d     = f_addr;
                            exp_idx_d  = SubIdxW'(1);
                            exp_addr_d = f_addr + AddrInc;
                        end else begin
                            exp_idx_d  = exp_idx_q + SubIdxW'(1);
                            exp_addr_d = exp_addr_q + AddrInc;
                        end
                        acc_d   = acc_sum[LSIZE-1:0];
                        base_d  = base_sel + PlenBeats;
                        state_d = frag_last ? StEmit : StAcc;
                    end
                end
            end
            StEmit: begin
                if (out_ready) state_d = StIdle;
            end
            StDrop: begin
                if (accept && frag_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered so that frag_ready stays low through reset and rises on the first clock after.
    assign ready_d = (state_d != StEmit);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ready_q    <= 1'b0;
            id_q       <= '0;
            addr_q     <= '0;
            acc_q      <= '0;
            base_q     <= '0;
            exp_idx_q  <= '0;
            exp_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            ready_q    <= ready_d;
            id_q       <= id_d;
            addr_q     <= addr_d;
            acc_q      <= acc_d;
            base_q     <= base_d;
            exp_idx_q  <= exp_idx_d;
            exp_addr_q <= exp_addr_d;
        end
    end

    assign frag_ready = ready_q;
    assign out_valid  = (state_q == StEmit);

    always_comb begin
        out_data                         = '0;
        out_data[OutIdLsb +: IDSIZE]     = id_q;
        out_data[OutAddrLsb +: ASIZE]    = addr_q;
        out_data[OutLenLsb +: LSIZE]     = acc_q;
    end

endmodule

// File: tb/tb_data_partition_merge.sv
// Self-checking bench for data_partition_merge: directed cases plus random legal transactions
// compared against a length/address model; violation cases need DATA_PARTITION_MERGE_CHECK_EN.
module tb_data_partition_merge;

    localparam int unsigned PLEN      = 128;
    localparam int unsigned LSIZE     = 12;
    localparam int unsigned IDSIZE    = 4;
    localparam int unsigned ASIZE     = 16;
    localparam int unsigned ADDR_STEP = 1;
    localparam int unsigned AddrInc   = ADDR_STEP * PLEN / 1024;

    typedef struct packed {
        logic [3:0]  sub;
        logic [3:0]  id;
        logic [15:0] addr;
        logic [11:0] len;
    } frag_t;

    logic        clock      = 1'b0;
    logic        rst_n      = 1'b0;
    logic        frag_valid = 1'b0;
    logic        frag_ready;
    logic [35:0] frag_data  = '0;
    logic        frag_last  = 1'b0;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [31:0] out_data;
    logic        err;
    logic [15:0] err_cnt;

    int n_checks    = 0;
    int n_fail      = 0;
    int exp_err_cnt = 0;

    data_partition_merge #(
        .PLEN      (PLEN),
        .LSIZE     (LSIZE),
        .IDSIZE    (IDSIZE),
        .ASIZE     (ASIZE),
        .ADDR_STEP (ADDR_STEP)
    ) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .frag_valid (frag_valid),
        .frag_ready (frag_ready),
        .frag_data  (frag_data),
        .frag_last  (frag_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Merged length-minus-one: every non-final fragment is a full PLEN beats.
    function automatic logic [31:0] model_merge(input int n, input logic [3:0] id,
                                                input logic [15:0] addr0, input logic [11:0] tail);
        int unsigned total_m1;
        total_m1 = (n - 1) * PLEN + tail;
        return {id, addr0, 12'(total_m1)};
    endfunction

    task automatic send_frag(input frag_t f, input logic last);
        bit ok;
        ok = 1'b0;
        @(negedge clock);
        frag_valid = 1'b1;
        frag_data  = f;
        frag_last  = last;
        for (int c = 0; c < 100 && !ok; c++) begin
            if (frag_ready) ok = 1'b1;
            @(posedge clock);
            if (!ok) @(negedge clock);
        end
        #1;
        frag_valid = 1'b0;
        frag_last  = 1'b0;
        check_eq("frag_accepted", ok, 1);
    endtask

    task automatic send_frags(input int n, input logic [3:0] id, input logic [15:0] addr0,
                              input logic [11:0] tail);
        for (int i = 0; i < n; i++) begin
            frag_t f;
            logic  last;
            last   = (i == n - 1);
            f.sub  = 4'(i);
            f.id   = id;
            f.addr = addr0 + 16'(i * AddrInc);
            f.len  = last ? tail : 12'(PLEN - 1);
            send_frag(f, last);
            if (!last) begin
                @(negedge clock);
                check_eq("no_early_valid", out_valid, 0);
                check_eq("no_err_mid", err, 0);
                repeat ($urandom_range(0, 1)) @(negedge clock);
            end
        end
    endtask

    task automatic wait_emit(input logic [31:0] exp, input int stall);
        @(negedge clock);
        check_eq("out_valid", out_valid, 1);
        check_eq("out_data", out_data, exp);
        check_eq("ready_low_emit", frag_ready, 0);
        check_eq("err_after_last", err, 0);
        check_eq("err_cnt", err_cnt, 16'(exp_err_cnt));
        for (int i = 0; i < stall; i++) begin
            @(negedge clock);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_data", out_data, exp);
            check_eq("hold_ready_low", frag_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic finish_emit();
        @(negedge clock);
        check_eq("valid_drop", out_valid, 0);
        check_eq("ready_after_emit", frag_ready, 1);
    endtask

    task automatic run_txn(input int n, input logic [3:0] id, input logic [15:0] addr0,
                           input logic [11:0] tail, input int stall, input logic [31:0] exp);
        send_frags(n, id, addr0, tail);
        wait_emit(exp, stall);
        finish_emit();
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_ready"}, frag_ready, 0);
        check_eq({tag, "_valid"}, out_valid, 0);
        check_eq({tag, "_data"}, out_data, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_errcnt"}, err_cnt, 0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        check_eq("ready_before_clk", frag_ready, 0);
        @(posedge clock);
        #1;
        check_eq("ready_rise", frag_ready, 1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        release_reset();

        // Single fragment, then a three-fragment merge.
        send_frags(1, 4'd3, 16'h0010, 12'd57);
        wait_emit({4'd3, 16'h0010, 12'd57}, 0);
        finish_emit();
        run_txn(3, 4'd5, 16'h0010, 12'd9, 2, {4'd5, 16'h0010, 12'd265});

        // Long backpressure with the next fragment already waiting.
        send_frags(2, 4'd7, 16'h1234, 12'd100);
        frag_data  = {4'd0, 4'd9, 16'hBEEF, 12'd3};
        frag_last  = 1'b1;
        frag_valid = 1'b1;
        wait_emit({4'd7, 16'h1234, 12'd228}, 20);
        send_frag({4'd0, 4'd9, 16'hBEEF, 12'd3}, 1'b1);
        wait_emit({4'd9, 16'hBEEF, 12'd3}, 0);
        finish_emit();

        // Sixteen full fragments plus a tail: the index wraps 15 -> 0.
        run_txn(17, 4'd2, 16'h0400, 12'd33, 1, {4'd2, 16'h0400, 12'd2081});

`ifdef DATA_PARTITION_MERGE_CHECK_EN
        send_frag({4'd0, 4'd8, 16'h0020, 12'd127}, 1'b0);
        send_frag({4'd2, 4'd8, 16'h0020, 12'd127}, 1'b0);
        @(negedge clock);
        exp_err_cnt++;
        check_eq("err_pulse", err, 1);
        check_eq("err_cnt_inc", err_cnt, 16'(exp_err_cnt));
        check_eq("viol_no_valid", out_valid, 0);
        send_frag({4'd3, 4'd8, 16'h0020, 12'd127}, 1'b0);
        @(negedge clock);
        check_eq("err_one_cycle", err, 0);
        check_eq("drop_no_valid", out_valid, 0);
        send_frag({4'd4, 4'd8, 16'h0020, 12'd7}, 1'b1);
        @(negedge clock);
        check_eq("drop_last_no_valid", out_valid, 0);
        check_eq("drop_no_err", err, 0);
        check_eq("drop_ready", frag_ready, 1);
        run_txn(2, 4'd8, 16'h0020, 12'd7, 0, {4'd8, 16'h0020, 12'd135});
`else
        // Unchecked build: a nonzero first index is simply the start of a transaction.
        send_frag({4'd5, 4'd1, 16'h0042, 12'd20}, 1'b1);
        wait_emit({4'd1, 16'h0042, 12'd20}, 0);
        finish_emit();
`endif

        // Reset after the first of three fragments.
        send_frag({4'd0, 4'd6, 16'h0777, 12'd127}, 1'b0);
        @(negedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        exp_err_cnt = 0;
        repeat (2) @(posedge clock);
        release_reset();
        run_txn(1, 4'd6, 16'h0777, 12'd44, 0, {4'd6, 16'h0777, 12'd44});

        repeat (40) begin
            int          n;
            int          stall;
            logic [3:0]  id;
            logic [15:0] addr0;
            logic [11:0] tail;
            n     = int'($urandom_range(1, 20));
            stall = int'($urandom_range(0, 3));
            id    = 4'($urandom);
            addr0 = 16'($urandom);
            tail  = 12'($urandom_range(0, PLEN - 1));
            run_txn(n, id, addr0, tail, stall, model_merge(n, id, addr0, tail));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
